// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode encodings and hazard-controller state type for the 16-bit CPU
package cpu_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ALU   = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    typedef enum logic {HZ_RUN, HZ_LU_HOLD} hz_state_e;

endpackage

// File: rtl/reg_use_decode.sv
// reg_use_decode: which source-register fields an opcode actually reads
import cpu_pkg::*;

module reg_use_decode (
    input  logic [4:0] opcode,
    output logic       uses_rs,
    output logic       uses_rt
);

    assign uses_rs = !(opcode inside {OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI});
    assign uses_rt = opcode inside {OP_ALU, OP_SHIFT, OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_ST, OP_STU};

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall, memory-busy freeze and redirect flush control with perf counters
import cpu_pkg::*;

module hazard_ctrl_unit #(
    parameter int INSTR_W   = 16,
    parameter int REG_W     = 3,
    parameter int LU_CYCLES = 1,
    parameter int STAT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] ifid_instr,
    input  logic [REG_W-1:0]   idex_rd,
    input  logic               idex_reg_wr,
    input  logic               idex_mem_rd,
    input  logic               idex_mem_wr,
    input  logic               ex_redirect,
    input  logic               mem_busy,
    output logic               pc_wr_en,
    output logic               ifid_wr_en,
    output logic               idex_bubble,
    output logic               ifid_flush,
    output logic               pipe_freeze,
    output logic [STAT_W-1:0]  stall_cnt,
    output logic [STAT_W-1:0]  flush_cnt
);

    hz_state_e  state, state_nxt;
    logic [1:0] lu_cnt, lu_cnt_nxt;
    logic       uses_rs, uses_rt, hit, stall, flush_ev;

    reg_use_decode u_dec (
        .opcode (ifid_instr[15:11]),
        .uses_rs(uses_rs),
        .uses_rt(uses_rt)
    );

    assign hit = idex_mem_rd & ~idex_mem_wr & idex_reg_wr &
                 ((uses_rs & (idex_rd == ifid_instr[10:8])) | (uses_rt & (idex_rd == ifid_instr[7:5])));
    assign stall    = ~mem_busy & ~ex_redirect & ((state == HZ_LU_HOLD) | hit);
    assign flush_ev = ~mem_busy & ex_redirect;

    // A frozen cycle falls through with state and lu_cnt unchanged.
    always_comb begin
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        if (flush_ev) begin
            state_nxt  = HZ_RUN;
            lu_cnt_nxt = 2'd0;
        end else if (stall && state == HZ_LU_HOLD) begin
            state_nxt  = (lu_cnt == 2'd1) ? HZ_RUN : HZ_LU_HOLD;
            lu_cnt_nxt = lu_cnt - 2'd1;
        end else if (stall && LU_CYCLES > 1) begin
            state_nxt  = HZ_LU_HOLD;
            lu_cnt_nxt = 2'(LU_CYCLES - 1);
        end
    end

    // Outputs fall back to idle values while reset is held.
    always_comb begin
        pipe_freeze = rst_n & mem_busy;
        ifid_flush  = rst_n & flush_ev;
        idex_bubble = rst_n & (flush_ev | stall);
        pc_wr_en    = ~rst_n | ~(mem_busy | stall);
        ifid_wr_en  = ~rst_n | ~(mem_busy | stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HZ_RUN;
            lu_cnt    <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: three DUTs (LU_CYCLES 1/2/3) against a remaining-bubbles reference model
module tb_hazard_ctrl_unit;

    localparam logic [15:0] ADD_R1_R3_R2 = {5'b11011, 3'd3, 3'd2, 3'd1, 2'b00};
    localparam logic [15:0] ST_R3_R5     = {5'b10000, 3'd5, 3'd3, 5'd0};
    localparam logic [15:0] LBI_R3_7     = {5'b11000, 3'd3, 8'd7};
    localparam logic [15:0] NOP_I        = {5'b00001, 11'd0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ifid_instr = NOP_I;
    logic [2:0]  idex_rd = 3'd0;
    logic        idex_reg_wr = 1'b0, idex_mem_rd = 1'b0, idex_mem_wr = 1'b0;
    logic        ex_redirect = 1'b0, mem_busy = 1'b0;
    logic [2:0]  pc, iw, bub, fl, frz;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;
    int          vec = 0, err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LU_CYCLES(1), .STAT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .idex_rd(idex_rd),
        .idex_reg_wr(idex_reg_wr), .idex_mem_rd(idex_mem_rd), .idex_mem_wr(idex_mem_wr),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_wr_en(pc[0]), .ifid_wr_en(iw[0]),
        .idex_bubble(bub[0]), .ifid_flush(fl[0]), .pipe_freeze(frz[0]), .stall_cnt(sc0), .flush_cnt(fc0));
    hazard_ctrl_unit #(.LU_CYCLES(2), .STAT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .idex_rd(idex_rd),
        .idex_reg_wr(idex_reg_wr), .idex_mem_rd(idex_mem_rd), .idex_mem_wr(idex_mem_wr),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_wr_en(pc[1]), .ifid_wr_en(iw[1]),
        .idex_bubble(bub[1]), .ifid_flush(fl[1]), .pipe_freeze(frz[1]), .stall_cnt(sc1), .flush_cnt(fc1));
    hazard_ctrl_unit #(.LU_CYCLES(3), .STAT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .idex_rd(idex_rd),
        .idex_reg_wr(idex_reg_wr), .idex_mem_rd(idex_mem_rd), .idex_mem_wr(idex_mem_wr),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_wr_en(pc[2]), .ifid_wr_en(iw[2]),
        .idex_bubble(bub[2]), .ifid_flush(fl[2]), .pipe_freeze(frz[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        logic [4:0] op;
        bit rs, rt;
        op = ifid_instr[15:11];
        rs = !(op inside {5'd0, 5'd1, 5'd4, 5'd6, 5'd24});
        rt = op inside {[5'd26:5'd31], 5'd16, 5'd19};
        return idex_mem_rd && !idex_mem_wr && idex_reg_wr &&
               ((rs && idex_rd == ifid_instr[10:8]) || (rt && idex_rd == ifid_instr[7:5]));
    endfunction

    // Model: per DUT, number of stall cycles still owed after the current one.
    int lu[3] = '{1, 2, 3};
    int mx[3] = '{65535, 65535, 15};
    int rem[3] = '{0, 0, 0};
    int ms[3] = '{0, 0, 0};
    int mf[3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit h, st, e_frz, e_fl;
            int sv, fv;
            if (!rst_n) begin
                rem[i] = 0;
                ms[i]  = 0;
                mf[i]  = 0;
            end
            h     = m_hit();
            st    = rst_n && !mem_busy && !ex_redirect && (rem[i] > 0 || h);
            e_frz = rst_n && mem_busy;
            e_fl  = rst_n && !mem_busy && ex_redirect;
            sv = (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
            fv = (i == 0) ? int'(fc0) : (i == 1) ? int'(fc1) : int'(fc2);
            chk($sformatf("u%0d.pc_wr_en", i + 1), int'(pc[i]), int'(!(e_frz || st)));
            chk($sformatf("u%0d.ifid_wr_en", i + 1), int'(iw[i]), int'(!(e_frz || st)));
            chk($sformatf("u%0d.idex_bubble", i + 1), int'(bub[i]), int'(st || e_fl));
            chk($sformatf("u%0d.ifid_flush", i + 1), int'(fl[i]), int'(e_fl));
            chk($sformatf("u%0d.pipe_freeze", i + 1), int'(frz[i]), int'(e_frz));
            chk($sformatf("u%0d.stall_cnt", i + 1), sv, ms[i]);
            chk($sformatf("u%0d.flush_cnt", i + 1), fv, mf[i]);
            if (rst_n && !mem_busy) begin
                if (ex_redirect) begin
                    rem[i] = 0;
                    if (mf[i] < mx[i]) mf[i]++;
                end else if (st) begin
                    rem[i] = (rem[i] > 0) ? rem[i] - 1 : lu[i] - 1;
                    if (ms[i] < mx[i]) ms[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [2:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic rdr, input logic bz);
        ifid_instr  = ins;
        idex_rd     = rd;
        idex_reg_wr = rw;
        idex_mem_rd = mr;
        idex_mem_wr = mw;
        ex_redirect = rdr;
        mem_busy    = bz;
    endtask

    task automatic idle();
        drive(NOP_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        idle();
        #1;
        chk("reset pc_wr_en", int'(pc[0]), 1);
        chk("reset stall_cnt", int'(sc0), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;

        // load-use with LU 1/2/3, memory busy during the hold
        do_reset();
        drive(ADD_R1_R3_R2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t1 pc_wr_en", int'(pc[0]), 0);
        chk("t1 idex_bubble", int'(bub[0]), 1);
        tick();
        idle();
        mem_busy = 1'b1;
        #1;
        chk("t2 pipe_freeze", int'(frz[1]), 1);
        chk("t2 bubble in freeze", int'(bub[1]), 0);
        tick();
        tick();
        tick();
        mem_busy = 1'b0;
        #1;
        chk("t1 stall_cnt", int'(sc0), 1);
        chk("t2 hold pc_wr_en", int'(pc[1]), 0);
        chk("t2 hold bubble", int'(bub[1]), 1);
        tick();
        chk("t2 release pc_wr_en", int'(pc[1]), 1);
        chk("t2 stall_cnt", int'(sc1), 2);
        chk("t2 lu3 still stalled", int'(pc[2]), 0);
        tick();
        chk("t2 lu3 stall_cnt", int'(sc2), 3);

        // rt field of a store, lbi uses nothing, store in ID/EX
        do_reset();
        drive(ST_R3_R5, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t3 st rt stall", int'(bub[0]), 1);
        tick();
        drive(LBI_R3_7, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t3 lbi no stall", int'(bub[0]), 0);
        tick();
        drive(ADD_R1_R3_R2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t3 store no stall", int'(bub[0]), 0);
        chk("t3 store pc_wr_en", int'(pc[0]), 1);

        // redirect abandons LU_HOLD
        do_reset();
        drive(ADD_R1_R3_R2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        ex_redirect = 1'b1;
        #1;
        chk("t4 ifid_flush", int'(fl[2]), 1);
        chk("t4 idex_bubble", int'(bub[2]), 1);
        chk("t4 pc_wr_en", int'(pc[2]), 1);
        tick();
        ex_redirect = 1'b0;
        #1;
        chk("t4 no further stall", int'(bub[2]), 0);
        chk("t4 flush_cnt", int'(fc2), 1);
        chk("t4 stall_cnt", int'(sc2), 1);

        // saturation of the 4-bit counter
        do_reset();
        drive(ADD_R1_R3_R2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        chk("t5 stall_cnt 16b", int'(sc0), 20);
        chk("t5 stall_cnt saturated", int'(sc2), 15);
        idle();

        // async reset mid-hold
        do_reset();
        drive(ADD_R1_R3_R2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async pc_wr_en", int'(pc[2]), 1);
        chk("t6 async bubble", int'(bub[2]), 0);
        chk("t6 async stall_cnt", int'(sc2), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6 post-reset bubble", int'(bub[2]), 0);
        tick();
        chk("t6 post-reset pc_wr_en", int'(pc[2]), 1);

        // randomized traffic, checked by the negedge model
        repeat (3000) begin
            tick();
            rst_n = ($urandom_range(99) != 0);
            drive({5'($urandom_range(31)), 3'($urandom_range(2, 5)), 3'($urandom_range(2, 5)), 5'($urandom)},
                  3'($urandom_range(2, 5)), $urandom_range(3) != 0, $urandom_range(1) == 1,
                  $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(6) == 0);
        end
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
